riscv_core_hazard: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage core.
- Takes decoded register usage from ID, branch resolution from EX, busy status from MEM and load writeback from WB.
- Tracks outstanding load destinations in a scoreboard and sequences branch shadows with a small FSM.
- Drives the stall, bubble and flush controls for IF, ID and EX.

---
 rtl/riscv_core_pkg.sv | 35 +++
 rtl/riscv_core_hazard_if.sv | 44 ++++
 rtl/riscv_core_scoreboard.sv | 39 +++
 rtl/riscv_core_hazard.sv | 169 ++++++++++++++++
 tb/tb_riscv_core_hazard.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the 5-stage core: hazard FSM state encoding,
// base opcodes and the one-hot FUNCT/MEM/BR control words used by decode.
// No ports; imported with `import riscv_core_pkg::*;`.
package riscv_core_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_BR_WAIT = 2'd1,
        HZ_FLUSH   = 2'd2
    } hz_state_e;

    // RV32I base opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // One-hot EX/MEM/BR control words; the *_NOP values form a bubble
    localparam logic [3:0] FUNCT_NOP  = 4'b0001;
    localparam logic [3:0] FUNCT_ADD  = 4'b0010;
    localparam logic [3:0] FUNCT_SUB  = 4'b0100;
    localparam logic [3:0] FUNCT_LOG  = 4'b1000;
    localparam logic [2:0] MEM_NOP    = 3'b001;
    localparam logic [2:0] MEM_LD     = 3'b010;
    localparam logic [2:0] MEM_ST     = 3'b100;
    localparam logic [2:0] BR_NOP     = 3'b001;
    localparam logic [2:0] BR_COND    = 3'b010;
    localparam logic [2:0] BR_JMP     = 3'b100;

endpackage

// File: rtl/riscv_core_hazard_if.sv
// Pipeline <-> hazard-unit bundle.
//   master: the pipeline stages (drive ID/EX/MEM/WB status, receive controls)
//   slave : the hazard unit (receives status, drives stall/bubble/flush)
interface riscv_core_hazard_if;
    import riscv_core_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic              id_rs1_used;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_load;
    logic              id_is_ctrl;
    logic              ex_br_resolve;
    logic              ex_br_taken;
    logic              mem_busy;
    logic              wb_load_valid;
    logic [REG_AW-1:0] wb_load_rd;

    logic              id_issue;
    logic              if_stall;
    logic              id_stall_back;
    logic              id_ex_bubble;
    logic              if_id_flush;
    logic [2:0]        pend_loads;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
               id_is_load, id_is_ctrl, ex_br_resolve, ex_br_taken,
               mem_busy, wb_load_valid, wb_load_rd,
        input  id_issue, if_stall, id_stall_back, id_ex_bubble,
               if_id_flush, pend_loads
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
               id_is_load, id_is_ctrl, ex_br_resolve, ex_br_taken,
               mem_busy, wb_load_valid, wb_load_rd,
        output id_issue, if_stall, id_stall_back, id_ex_bubble,
               if_id_flush, pend_loads
    );

endinterface

// File: rtl/riscv_core_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register x1..x31,
// set when a load issues, cleared when it writes back.
// Ports: clk, rst (sync, active-high), set_en/set_idx, clr_en/clr_idx,
//        rd_idx_a/rd_a and rd_idx_b/rd_b (combinational read of current state).
module riscv_core_scoreboard
    import riscv_core_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic [REG_AW-1:0] rd_idx_a,
    input  logic [REG_AW-1:0] rd_idx_b,
    output logic              rd_a,
    output logic              rd_b
);

    // Bit 0 is kept for uniform indexing and is held at zero (x0 never pends).
    logic [31:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en && clr_idx != '0) sb_d[clr_idx] = 1'b0;
        // Set after clear: a newer load owns the register.
        if (set_en && set_idx != '0) sb_d[set_idx] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) sb_q <= '0;
        else     sb_q <= sb_d;
    end

    assign rd_a = sb_q[rd_idx_a];
    assign rd_b = sb_q[rd_idx_b];

endmodule

// File: rtl/riscv_core_hazard.sv
// Hazard and stall controller for the 5-stage core.
// Ports: clk, rst (sync, active-high), hz (riscv_core_hazard_if.slave) carrying
//        ID decode info, EX branch resolution, MEM busy, WB load retire and the
//        IF/ID/EX stall, bubble and flush controls plus pend_loads.
// Optional: define HAZARD_PERF_CNT_EN to add perf_raw_stall, perf_br_stall and
//           perf_busy_stall saturating cycle counters (CNT_W bits).
//
//   state      | meaning
//   HZ_RUN     | normal issue; stalls only on load-use RAW or load-queue full
//   HZ_BR_WAIT | control transfer in EX, hold fetch until it resolves
//   HZ_FLUSH   | taken transfer: squash the wrong-path IF/ID instruction
module riscv_core_hazard
    import riscv_core_pkg::*;
#(
    parameter int MAX_LOADS = 2,
    parameter int CNT_W     = 32
) (
    input  logic clk,
    input  logic rst,
    riscv_core_hazard_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_raw_stall,
    output logic [CNT_W-1:0] perf_br_stall,
    output logic [CNT_W-1:0] perf_busy_stall
`endif
);

    if (MAX_LOADS < 1 || MAX_LOADS > 7) begin : g_bad_max_loads
        $error("MAX_LOADS must be within 1..7");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    localparam logic [2:0] MAX_LD = 3'(MAX_LOADS);

    hz_state_e  state_q, state_d;
    logic [2:0] ld_cnt_q, ld_cnt_d;
    logic       sb_rs1, sb_rs2, raw, ld_full, load_issue;
    logic       issue, stall, bubble, flush;
    logic       raw_stall_cyc, br_cyc, busy_cyc;

    riscv_core_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (load_issue),
        .set_idx  (hz.id_rd),
        .clr_en   (hz.wb_load_valid),
        .clr_idx  (hz.wb_load_rd),
        .rd_idx_a (hz.id_rs1),
        .rd_idx_b (hz.id_rs2),
        .rd_a     (sb_rs1),
        .rd_b     (sb_rs2)
    );

    always_comb begin
        state_d       = state_q;
        issue         = 1'b0;
        stall         = 1'b0;
        bubble        = 1'b0;
        flush         = 1'b0;
        raw_stall_cyc = 1'b0;
        br_cyc        = 1'b0;
        busy_cyc      = 1'b0;

        raw     = (hz.id_rs1_used && hz.id_rs1 != '0 && sb_rs1) ||
                  (hz.id_rs2_used && hz.id_rs2 != '0 && sb_rs2);
        ld_full = hz.id_is_load && (ld_cnt_q == MAX_LD);

        if (rst) begin
            state_d = HZ_RUN;
        end else if (hz.mem_busy) begin
            // Whole pipe freezes; no bubble since EX is held too.
            stall    = 1'b1;
            busy_cyc = 1'b1;
        end else begin
            unique case (state_q)
                HZ_FLUSH: begin
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    br_cyc  = 1'b1;
                    state_d = HZ_RUN;
                end
                HZ_BR_WAIT: begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    br_cyc = 1'b1;
                    if (hz.ex_br_resolve)
                        state_d = hz.ex_br_taken ? HZ_FLUSH : HZ_RUN;
                end
                default: begin
                    if (hz.id_valid && (raw || ld_full)) begin
                        stall         = 1'b1;
                        bubble        = 1'b1;
                        raw_stall_cyc = 1'b1;
                    end else begin
                        // A resolve seen here cannot belong to anything in flight.
                        issue = hz.id_valid;
                        if (issue && hz.id_is_ctrl) state_d = HZ_BR_WAIT;
                    end
                end
            endcase
        end

        load_issue = issue && hz.id_is_load;

        ld_cnt_d = ld_cnt_q;
        if (load_issue && !hz.wb_load_valid)
            ld_cnt_d = ld_cnt_q + 3'd1;
        else if (!load_issue && hz.wb_load_valid && ld_cnt_q != '0)
            ld_cnt_d = ld_cnt_q - 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HZ_RUN;
            ld_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
        end
    end

    assign hz.id_issue      = issue;
    assign hz.if_stall      = stall;
    assign hz.id_stall_back = stall;
    assign hz.id_ex_bubble  = bubble;
    assign hz.if_id_flush   = flush;
    assign hz.pend_loads    = rst ? 3'd0 : ld_cnt_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(hz.wb_load_valid && ld_cnt_q == 3'd0));

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] perf_raw_q, perf_raw_d;
    logic [CNT_W-1:0] perf_br_q, perf_br_d;
    logic [CNT_W-1:0] perf_busy_q, perf_busy_d;

    always_comb begin
        perf_raw_d  = perf_raw_q;
        perf_br_d   = perf_br_q;
        perf_busy_d = perf_busy_q;
        if (raw_stall_cyc && perf_raw_q  != '1) perf_raw_d  = perf_raw_q  + 1'b1;
        if (br_cyc        && perf_br_q   != '1) perf_br_d   = perf_br_q   + 1'b1;
        if (busy_cyc      && perf_busy_q != '1) perf_busy_d = perf_busy_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_raw_q  <= '0;
            perf_br_q   <= '0;
            perf_busy_q <= '0;
        end else begin
            perf_raw_q  <= perf_raw_d;
            perf_br_q   <= perf_br_d;
            perf_busy_q <= perf_busy_d;
        end
    end

    assign perf_raw_stall  = perf_raw_q;
    assign perf_br_stall   = perf_br_q;
    assign perf_busy_stall = perf_busy_q;
`else
    logic unused_perf;
    assign unused_perf = raw_stall_cyc ^ br_cyc ^ busy_cyc;
`endif

endmodule

// File: tb/tb_riscv_core_hazard.sv
// Directed bench for riscv_core_hazard with MAX_LOADS=2.
// Control outputs are compared as {id_issue, if_stall, id_stall_back,
// id_ex_bubble, if_id_flush}.
module tb_riscv_core_hazard;
    import riscv_core_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    riscv_core_hazard_if hz ();

    riscv_core_hazard #(.MAX_LOADS(2), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_ISSUE = 5'b10000;
    localparam logic [4:0] O_STALL = 5'b01110;
    localparam logic [4:0] O_BUSY  = 5'b01100;
    localparam logic [4:0] O_FLUSH = 5'b00011;

    logic [4:0] outs;
    assign outs = {hz.id_issue, hz.if_stall, hz.id_stall_back,
                   hz.id_ex_bubble, hz.if_id_flush};

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs1_used = 0;
        hz.id_rs2 = 0; hz.id_rs2_used = 0; hz.id_rd = 0;
        hz.id_is_load = 0; hz.id_is_ctrl = 0;
        hz.ex_br_resolve = 0; hz.ex_br_taken = 0; hz.mem_busy = 0;
        hz.wb_load_valid = 0; hz.wb_load_rd = 0;
    endtask

    task automatic ld(input logic [4:0] rd);
        idle();
        hz.id_valid = 1; hz.id_is_load = 1; hz.id_rd = rd;
    endtask

    task automatic alu(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        idle();
        hz.id_valid = 1; hz.id_rs1 = rs1; hz.id_rs1_used = 1;
        hz.id_rs2 = rs2; hz.id_rs2_used = 1; hz.id_rd = rd;
    endtask

    task automatic br();
        idle();
        hz.id_valid = 1; hz.id_is_ctrl = 1;
    endtask

    task automatic wb(input logic [4:0] rd);
        hz.wb_load_valid = 1; hz.wb_load_rd = rd;
    endtask

    // settle combinational outputs, then compare
    task automatic expect_outs(input string tag, input logic [4:0] o, input logic [2:0] p);
        #1;
        check_val({tag, "_ctl"}, 32'(outs), 32'(o));
        check_val({tag, "_pend"}, 32'(hz.pend_loads), 32'(p));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1;
        ld(5'd3);
        expect_outs("rst_force", O_IDLE, 3'd0);
        tick(); tick();
        rst = 0;
        idle();
        expect_outs("post_rst", O_IDLE, 3'd0);
        tick();

        // load-use
        ld(5'd5);              expect_outs("lw_x5", O_ISSUE, 3'd0); tick();
        alu(5'd5, 5'd1, 5'd6); expect_outs("lu_stall1", O_STALL, 3'd1); tick();
        expect_outs("lu_stall2", O_STALL, 3'd1);
        wb(5'd5);              expect_outs("lu_stall_wb", O_STALL, 3'd1); tick();
        alu(5'd5, 5'd1, 5'd6); expect_outs("lu_issue", O_ISSUE, 3'd0); tick();

        // x0 destination never creates a hazard but still counts
        ld(5'd0);              expect_outs("lw_x0", O_ISSUE, 3'd0); tick();
        alu(5'd0, 5'd0, 5'd6); expect_outs("x0_nostall", O_ISSUE, 3'd1); tick();
        idle(); wb(5'd0);      expect_outs("x0_wb", O_IDLE, 3'd1); tick();
        idle();                expect_outs("x0_done", O_IDLE, 3'd0);

        // MAX_LOADS=2 limit
        ld(5'd1);              expect_outs("ld1", O_ISSUE, 3'd0); tick();
        ld(5'd2);              expect_outs("ld2", O_ISSUE, 3'd1); tick();
        ld(5'd3);              expect_outs("ld3_full", O_STALL, 3'd2); tick();
        expect_outs("ld3_full2", O_STALL, 3'd2);
        wb(5'd1);              expect_outs("ld3_full_wb", O_STALL, 3'd2); tick();
        ld(5'd3);              expect_outs("ld3_issue", O_ISSUE, 3'd1); tick();
        idle(); wb(5'd2);      expect_outs("drain2", O_IDLE, 3'd2); tick();
        ld(5'd4); wb(5'd3);    expect_outs("ld4_wb3", O_ISSUE, 3'd1); tick();
        idle();                expect_outs("ld4_hold", O_IDLE, 3'd1);
        wb(5'd4);              tick();
        idle();                expect_outs("drain_all", O_IDLE, 3'd0);

        // set wins over clear on the same register
        ld(5'd9);              expect_outs("ld9a", O_ISSUE, 3'd0); tick();
        ld(5'd9); wb(5'd9);    expect_outs("ld9b_wb9", O_ISSUE, 3'd1); tick();
        alu(5'd2, 5'd9, 5'd10); expect_outs("ld9_raw", O_STALL, 3'd1);
        wb(5'd9);              tick();
        alu(5'd2, 5'd9, 5'd10); expect_outs("ld9_clear", O_ISSUE, 3'd0); tick();

        // taken branch
        br();                  expect_outs("beq_t", O_ISSUE, 3'd0); tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("brw1", O_STALL, 3'd0); tick();
        hz.ex_br_resolve = 1; hz.ex_br_taken = 1;
        expect_outs("brw_res_t", O_STALL, 3'd0); tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("flush", O_FLUSH, 3'd0); tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("after_flush", O_ISSUE, 3'd0); tick();

        // not-taken branch; resolve during issue is ignored
        br(); hz.ex_br_resolve = 1; hz.ex_br_taken = 1;
        expect_outs("beq_nt", O_ISSUE, 3'd0); tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("brw_ign", O_STALL, 3'd0);
        hz.ex_br_resolve = 1; tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("nt_run", O_ISSUE, 3'd0); tick();

        // mem_busy during RAW stall, WB clear still lands
        ld(5'd7);              tick();
        alu(5'd7, 5'd0, 5'd8); expect_outs("raw7", O_STALL, 3'd1); tick();
        hz.mem_busy = 1;       expect_outs("busy1", O_BUSY, 3'd1); tick();
        wb(5'd7);              expect_outs("busy2", O_BUSY, 3'd1); tick();
        hz.wb_load_valid = 0;  expect_outs("busy3", O_BUSY, 3'd0); tick();
        hz.mem_busy = 0;       expect_outs("raw7_clr", O_ISSUE, 3'd0); tick();

        // mem_busy freezes BR_WAIT and masks a resolve
        br();                  tick();
        alu(5'd1, 5'd2, 5'd3); hz.mem_busy = 1; hz.ex_br_resolve = 1; hz.ex_br_taken = 1;
        expect_outs("brw_busy", O_BUSY, 3'd0); tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("brw_frozen", O_STALL, 3'd0);
        hz.ex_br_resolve = 1;  tick();
        alu(5'd1, 5'd2, 5'd3); expect_outs("brw_exit", O_ISSUE, 3'd0); tick();

        // reset in BR_WAIT with sb[7]=1, ld_cnt=2
        ld(5'd7);              tick();
        ld(5'd8);              tick();
        br();                  expect_outs("pre_rst_br", O_ISSUE, 3'd2); tick();
        alu(5'd7, 5'd8, 5'd9); expect_outs("pre_rst_wait", O_STALL, 3'd2);
        rst = 1;               expect_outs("rst_in_brw", O_IDLE, 3'd0); tick();
        rst = 0;
        alu(5'd7, 5'd8, 5'd9); expect_outs("post_rst_run", O_ISSUE, 3'd0); tick();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
